pe_8x4_seq_loader: RTL
======================

Name: pe_8x4_seq_loader

Overview:
- Stream-side driver for the 8-input, 4-output, 16-bit processing element.
- Deserialises a 16-bit word stream into the PE's wide WEIGHT (32 words) and DATA (8 words) buses.
- Drives the PE clock enable for a fixed pipeline window, captures the PE's Q bus, and serialises the 4 neuron outputs back out on a valid/ready stream.
- Sits between the reservoir controller/FIFO fabric and one PE instance.

Parameters:
- WORD_LEN, 16, word width in bits. Synapses are Q0.15; outputs are Q0.15.
- NEU_IN, 8, input neurons per PE, i.e. DATA words per run.
- NEU_OUT, 4, output neurons per PE, i.e. Q words per run.
- PE_LAT, 2, clock cycles from DATA/WEIGHT stable to a valid transfer-function result at the PE's Q register input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle run request; sampled only in IDLE
- start_w  in  1  qualifier for start: 1 = load weights then data, 0 = data only (reuse held weights)
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  WORD_LEN  weight or data word
- DATA  out  WORD_LEN*NEU_IN  to PE DATA bus
- WEIGHT  out  WORD_LEN*NEU_IN*NEU_OUT  to PE WEIGHT bus
- pe_ce  out  1  to PE ce
- pe_q  in  WORD_LEN*NEU_OUT  from PE Q
- out_valid  out  1  output word valid
- out_ready  in  1  output word consumed when out_valid & out_ready
- out_data  out  WORD_LEN  neuron output word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last output word is accepted

Behaviour:
- Reset (rst=1 at a clock edge, in any state including mid-load or mid-drain):
  - state goes to IDLE
  - DATA, WEIGHT, the output buffer and all counters go to 0
  - pe_ce, in_ready, out_valid, busy and done go to 0
  - Weights are lost.
- States: IDLE, LOAD_W, LOAD_D, FIRE, DRAIN.
- IDLE:
  - start=1 moves to LOAD_W if start_w=1, otherwise to LOAD_D; the new state is active the next cycle.
  - start is ignored in every other state.
- LOAD_W:
  - in_ready=1.
  - Accepted word k (k = 0..31) is written to WEIGHT[16k+15:16k]. Index order matches the PE: weight n*8+i feeds output n from input i.
  - After word 31 is accepted, go to LOAD_D. No other weight slice changes during the load.
- LOAD_D:
  - in_ready=1.
  - Accepted word k (k = 0..7) is written to DATA[16k+15:16k].
  - After word 7 is accepted, go to FIRE.
- Stalls: in_valid low stalls LOAD_W and LOAD_D indefinitely with no timeout.
- FIRE:
  - in_ready=0; pe_ce=1 for exactly PE_LAT+1 consecutive cycles (down-counter).
  - DATA and WEIGHT are held stable.
  - On the edge ending the last FIRE cycle, the output buffer is loaded with pe_q and the state moves to DRAIN.
  - pe_ce returns to 0 in the first DRAIN cycle, so the PE holds Q.
- DRAIN:
  - out_valid=1 and out_data = buffer word j, j = 0..3, where word 0 = pe_q[15:0].
  - j advances only on out_valid & out_ready; out_data is stable while stalled.
  - On acceptance of word 3: done=1 in that same cycle, then IDLE next cycle with out_valid=0.
- Latency (data-only run, back-to-back input and output):
  - start at cycle 0, LOAD_D at cycles 1..8, FIRE at cycles 9..9+PE_LAT.
  - First out_valid at cycle 10+PE_LAT; done at cycle 13+PE_LAT.
- Arithmetic: no arithmetic in this block. Words pass through bit-exact; no saturation or sign handling.
- Persistence: WEIGHT and DATA hold their values after the run, so a data-only run reuses the last loaded weights.
- busy=1 from the cycle after start is accepted until return to IDLE.

Test Plan:
- Reset then weight run: start=1, start_w=1, weights 0x0001..0x0020, data 0x0100..0x0107, pe_q tied to 0x4444_3333_2222_1111 → WEIGHT[15:0]=0x0001, WEIGHT[511:496]=0x0020, DATA[127:112]=0x0107; pe_ce high for 3 cycles; out_data sequence 0x1111, 0x2222, 0x3333, 0x4444; done pulses once.
- Data-only run after the above with data 0x7FFF×8 → WEIGHT unchanged (still 0x0001..0x0020); first out_valid exactly 12 cycles after start (PE_LAT=2); in_ready never high during FIRE.
- in_valid toggled 1-0-1 and out_ready held low for 5 cycles in DRAIN → no words skipped or duplicated; out_data holds 0x1111 through the stall; busy stays 1.
- start pulsed during LOAD_D and during DRAIN → ignored; word counters and state are unaffected.
- rst asserted after weight word 17 is accepted → next cycle: WEIGHT=0, DATA=0, busy=0, in_ready=0; a fresh weight run then loads correctly from slot 0.

Source files
------------

// File: rtl/pe_8x4_seq_loader.sv
// Stream-side loader/drainer for one 8-in, 4-out processing element.
// Deserialises weight/data words onto the PE buses, fires the PE, then serialises Q.
module pe_8x4_seq_loader #(
  parameter int unsigned WORD_LEN = 16,
  parameter int unsigned NEU_IN   = 8,
  parameter int unsigned NEU_OUT  = 4,
  parameter int unsigned PE_LAT   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 start_w,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WORD_LEN-1:0]                  in_data,
  output logic [WORD_LEN*NEU_IN-1:0]           DATA,
  output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]   WEIGHT,
  output logic                                 pe_ce,
  input  logic [WORD_LEN*NEU_OUT-1:0]          pe_q,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WORD_LEN-1:0]                  out_data,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned NumW   = NEU_IN * NEU_OUT;
  localparam int unsigned CntMax = (NumW > PE_LAT + 1) ? NumW : PE_LAT + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned OutW   = (NEU_OUT > 1) ? $clog2(NEU_OUT) : 1;

  typedef enum logic [2:0] {StIdle, StLoadW, StLoadD, StFire, StDrain} state_e;

  state_e                              state_q, state_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [WORD_LEN*NEU_IN-1:0]          data_q, data_d;
  logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  weight_q, weight_d;
  logic [WORD_LEN*NEU_OUT-1:0]         obuf_q, obuf_d;
  logic [OutW-1:0]                     out_sel;

  // One counter is shared: load word index, FIRE down-count, then drain index.
  assign out_sel  = cnt_q[OutW-1:0];
  assign out_data = obuf_q[WORD_LEN*int'(out_sel) +: WORD_LEN];
  assign busy     = (state_q != StIdle);
  assign DATA     = data_q;
  assign WEIGHT   = weight_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    weight_d  = weight_q;
    obuf_d    = obuf_q;
    in_ready  = 1'b0;
    pe_ce     = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = start_w ? StLoadW : StLoadD;
          cnt_d   = '0;
        end
      end
      StLoadW: begin
        in_ready = 1'b1;
        if (in_valid) begin
          weight_d[WORD_LEN*int'(cnt_q) +: WORD_LEN] = in_data;
          if (cnt_q == CntW'(NumW - 1)) begin
            state_d = StLoadD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StLoadD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d[WORD_LEN*int'(cnt_q) +: WORD_LEN] = in_data;
          if (cnt_q == CntW'(NEU_IN - 1)) begin
            state_d = StFire;
            cnt_d   = CntW'(PE_LAT);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFire: begin
        pe_ce = 1'b1;
        if (cnt_q == '0) begin
          // Counter is already 0 here, so the drain index starts at word 0.
          obuf_d  = pe_q;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt_q == CntW'(NEU_OUT - 1)) begin
            done    = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      data_q   <= '0;
      weight_q <= '0;
      obuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      weight_q <= weight_d;
      obuf_q   <= obuf_d;
    end
  end

endmodule
